// File: rtl/asy_fifo_wr_arbiter.sv
// Round-robin, burst-holding arbiter that shares the async FIFO write port
// among NUM_REQ wr_clk-domain producers, gated by the FIFO full flag.
module asy_fifo_wr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned STALL_MAX = 4
) (
    input  logic                       wr_clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ-1:0]         i_req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_fifo_wr_full,
    output logic                       o_fifo_wr_en,
    output logic [WIDTH-1:0]           o_fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy,
    output logic                       o_burst_abort
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam int unsigned SW = 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       r_state;
    logic [GW-1:0]    r_rr_ptr;
    logic [GW-1:0]    r_grant_id;
    logic [BW-1:0]    r_beat_cnt;
    logic [SW-1:0]    r_stall_cnt;
    logic             r_burst_abort;
    logic [WIDTH-1:0] r_data_hold;

    logic [0:0]       w_state_nxt;
    logic [GW-1:0]    w_rr_ptr_nxt;
    logic [GW-1:0]    w_grant_id_nxt;
    logic [BW-1:0]    w_beat_cnt_nxt;
    logic [SW-1:0]    w_stall_cnt_nxt;
    logic             w_burst_abort_nxt;
    logic [WIDTH-1:0] w_data_hold_nxt;

    logic             w_busy;
    logic             w_g_valid;
    logic             w_g_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_slice;
    logic             w_found;
    logic [GW-1:0]    w_sel;
    logic [GW-1:0]    w_idx;

    assign w_busy    = (r_state == S_BURST);
    assign w_g_valid = i_req_valid[r_grant_id];
    assign w_g_last  = i_req_last[r_grant_id];
    assign w_slice   = i_req_data[r_grant_id*WIDTH +: WIDTH];
    assign w_accept  = w_busy & w_g_valid & ~i_fifo_wr_full;

    // Write strobe is suppressed while reset is high so an in-flight beat is dropped cleanly
    assign o_fifo_wr_en   = w_accept & ~reset;
    assign o_fifo_data_in = w_busy ? w_slice : r_data_hold;
    assign o_grant_id     = r_grant_id;
    assign o_busy         = w_busy;
    assign o_burst_abort  = r_burst_abort;

    always_comb begin
        o_req_ready = '0;
        if (w_busy && !reset) begin
            o_req_ready[r_grant_id] = ~i_fifo_wr_full;
        end
    end

    // First valid requester at or above rr_ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = r_rr_ptr + GW'(i);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_grant_id_nxt    = r_grant_id;
        w_beat_cnt_nxt    = r_beat_cnt;
        w_stall_cnt_nxt   = r_stall_cnt;
        w_burst_abort_nxt = 1'b0;
        w_data_hold_nxt   = r_data_hold;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_BURST;
                    w_grant_id_nxt  = w_sel;
                    w_beat_cnt_nxt  = '0;
                    w_stall_cnt_nxt = '0;
                end
            end
            S_BURST: begin
                w_data_hold_nxt = w_slice;
                if (w_accept) begin
                    w_beat_cnt_nxt  = r_beat_cnt + BW'(1);
                    w_stall_cnt_nxt = '0;
                    if (w_g_last || (r_beat_cnt == BW'(BURST_MAX - 1))) begin
                        w_state_nxt  = S_IDLE;
                        w_rr_ptr_nxt = r_grant_id + GW'(1);
                    end
                end else if (!w_g_valid) begin
                    // Backpressure with valid held high never reaches this branch
                    w_stall_cnt_nxt = r_stall_cnt + SW'(1);
                    if (r_stall_cnt == SW'(STALL_MAX - 1)) begin
                        w_state_nxt       = S_IDLE;
                        w_rr_ptr_nxt      = r_grant_id + GW'(1);
                        w_burst_abort_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_beat_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_burst_abort <= 1'b0;
            r_data_hold   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_stall_cnt   <= w_stall_cnt_nxt;
            r_burst_abort <= w_burst_abort_nxt;
            r_data_hold   <= w_data_hold_nxt;
        end
    end

endmodule

// File: tb/tb_asy_fifo_wr_arbiter.sv
// Directed bench for asy_fifo_wr_arbiter with default parameters (4 requesters,
// 8-bit data, BURST_MAX=8, STALL_MAX=4).
module tb_asy_fifo_wr_arbiter;

    logic        wr_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;
    logic        burst_abort;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;
    int base;
    logic [1:0] exp_g;

    asy_fifo_wr_arbiter #(
        .WIDTH(8), .NUM_REQ(4), .BURST_MAX(8), .STALL_MAX(4)
    ) dut (
        .wr_clk         (wr_clk),
        .reset          (reset),
        .i_req_valid    (req_valid),
        .i_req_last     (req_last),
        .i_req_data     (req_data),
        .o_req_ready    (req_ready),
        .i_fifo_wr_full (fifo_wr_full),
        .o_fifo_wr_en   (fifo_wr_en),
        .o_fifo_data_in (fifo_data_in),
        .o_grant_id     (grant_id),
        .o_busy         (busy),
        .o_burst_abort  (burst_abort)
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) begin
        if (fifo_wr_en) wr_count <= wr_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] v);
        req_data[idx*8 +: 8] = v;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_wr_full = 1'b0;
        #3;
        chk("rst_busy",  32'(busy), 32'(0));
        chk("rst_abort", 32'(burst_abort), 32'(0));
        chk("rst_wren",  32'(fifo_wr_en), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        step(); step();
        reset = 1'b0;

        // Single requester 2, three beats
        req_valid = 4'b0100; set_data(2, 8'hA1); #1;
        chk("t1_idle_ready", 32'(req_ready), 32'(0));
        chk("t1_idle_wren",  32'(fifo_wr_en), 32'(0));
        step(); #1;
        chk("t1_grant", 32'(grant_id), 32'(2));
        chk("t1_busy",  32'(busy), 32'(1));
        chk("t1_ready", 32'(req_ready), 32'(4'b0100));
        chk("t1_wen1",  32'(fifo_wr_en), 32'(1));
        chk("t1_dat1",  32'(fifo_data_in), 32'(8'hA1));
        step(); set_data(2, 8'hA2); #1;
        chk("t1_wen2", 32'(fifo_wr_en), 32'(1));
        chk("t1_dat2", 32'(fifo_data_in), 32'(8'hA2));
        step(); set_data(2, 8'hA3); req_last = 4'b0100; #1;
        chk("t1_wen3", 32'(fifo_wr_en), 32'(1));
        chk("t1_dat3", 32'(fifo_data_in), 32'(8'hA3));
        step(); req_valid = '0; req_last = '0; #1;
        chk("t1_end_busy",  32'(busy), 32'(0));
        chk("t1_end_wen",   32'(fifo_wr_en), 32'(0));
        chk("t1_hold_data", 32'(fifo_data_in), 32'(8'hA3));
        chk("t1_abort",     32'(burst_abort), 32'(0));
        chk("t1_writes",    32'(wr_count), 32'(3));

        // All valid, no last: rotation starts at rr_ptr=3
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'hB0 + i));
        for (int b = 0; b < 5; b++) begin
            exp_g = 2'((3 + b) % 4);
            step(); #1;
            chk("t2_grant", 32'(grant_id), 32'(exp_g));
            chk("t2_busy",  32'(busy), 32'(1));
            base = wr_count;
            for (int k = 0; k < 8; k++) begin
                chk("t2_wen",  32'(fifo_wr_en), 32'(1));
                chk("t2_data", 32'(fifo_data_in), 32'(8'hB0 + 8'(exp_g)));
                step(); #1;
            end
            chk("t2_gap_busy", 32'(busy), 32'(0));
            chk("t2_gap_wen",  32'(fifo_wr_en), 32'(0));
            chk("t2_abort",    32'(burst_abort), 32'(0));
            chk("t2_writes",   32'(wr_count - base), 32'(8));
        end

        // Full backpressure on requester 1 for 10 cycles
        req_valid = 4'b0010; set_data(1, 8'hC0);
        step(); #1;
        base = wr_count;
        chk("t3_grant", 32'(grant_id), 32'(1));
        chk("t3_wen0",  32'(fifo_wr_en), 32'(1));
        chk("t3_dat0",  32'(fifo_data_in), 32'(8'hC0));
        step(); set_data(1, 8'hC1); fifo_wr_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t3_full_ready", 32'(req_ready), 32'(0));
            chk("t3_full_wen",   32'(fifo_wr_en), 32'(0));
            chk("t3_full_busy",  32'(busy), 32'(1));
            chk("t3_full_abort", 32'(burst_abort), 32'(0));
            step();
        end
        fifo_wr_full = 1'b0; #1;
        chk("t3_res_ready", 32'(req_ready), 32'(4'b0010));
        chk("t3_res_wen",   32'(fifo_wr_en), 32'(1));
        chk("t3_res_data",  32'(fifo_data_in), 32'(8'hC1));
        step(); set_data(1, 8'hC2); req_last = 4'b0010; #1;
        chk("t3_last_wen",  32'(fifo_wr_en), 32'(1));
        chk("t3_last_data", 32'(fifo_data_in), 32'(8'hC2));
        step(); req_valid = '0; req_last = '0; #1;
        chk("t3_end_busy", 32'(busy), 32'(0));
        chk("t3_abort",    32'(burst_abort), 32'(0));
        chk("t3_writes",   32'(wr_count - base), 32'(3));

        // Requester 0 stalls for STALL_MAX cycles; requester 1 waits
        req_valid = 4'b0001; set_data(0, 8'hD0);
        step(); #1;
        chk("t4_grant", 32'(grant_id), 32'(0));
        chk("t4_wen",   32'(fifo_wr_en), 32'(1));
        step(); req_valid = 4'b0010; set_data(1, 8'hE0); #1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_stall_busy",  32'(busy), 32'(1));
            chk("t4_stall_abort", 32'(burst_abort), 32'(0));
            chk("t4_stall_wen",   32'(fifo_wr_en), 32'(0));
            chk("t4_stall_ready", 32'(req_ready), 32'(4'b0001));
            step(); #1;
        end
        chk("t4_abort_pulse", 32'(burst_abort), 32'(1));
        chk("t4_abort_busy",  32'(busy), 32'(0));
        step(); #1;
        chk("t4_abort_clr", 32'(burst_abort), 32'(0));
        chk("t4_next_gnt",  32'(grant_id), 32'(1));
        chk("t4_next_busy", 32'(busy), 32'(1));
        chk("t4_next_data", 32'(fifo_data_in), 32'(8'hE0));
        req_last = 4'b0010;
        step(); req_valid = '0; req_last = '0; #1;
        chk("t4_end_busy",  32'(busy), 32'(0));
        chk("t4_end_abort", 32'(burst_abort), 32'(0));

        // Reset on the second beat of a burst
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'hF0 + i));
        step(); #1;
        base = wr_count;
        chk("t5_grant", 32'(grant_id), 32'(2));
        chk("t5_dat1",  32'(fifo_data_in), 32'(8'hF2));
        step(); reset = 1'b1; #1;
        chk("t5_rst_wen",   32'(fifo_wr_en), 32'(0));
        chk("t5_rst_busy",  32'(busy), 32'(0));
        chk("t5_rst_ready", 32'(req_ready), 32'(0));
        chk("t5_rst_grant", 32'(grant_id), 32'(0));
        chk("t5_rst_abort", 32'(burst_abort), 32'(0));
        step(); reset = 1'b0; #1;
        chk("t5_idle_busy", 32'(busy), 32'(0));
        chk("t5_writes",    32'(wr_count - base), 32'(1));
        step(); #1;
        chk("t5_regrant", 32'(grant_id), 32'(0));
        chk("t5_rebusy",  32'(busy), 32'(1));
        chk("t5_redata",  32'(fifo_data_in), 32'(8'hF0));
        req_last = 4'b1111;
        step(); req_valid = '0; req_last = '0; #1;
        chk("t5_end_busy", 32'(busy), 32'(0));

        // req_last coincides with the BURST_MAX-th beat
        req_valid = 4'b0010;
        step(); #1;
        base = wr_count;
        chk("t6_grant", 32'(grant_id), 32'(1));
        for (int k = 0; k < 8; k++) begin
            set_data(1, 8'(8'h60 + k));
            req_last = (k == 7) ? 4'b0010 : 4'b0000;
            #1;
            chk("t6_wen",  32'(fifo_wr_en), 32'(1));
            chk("t6_data", 32'(fifo_data_in), 32'(8'h60 + k));
            step(); #1;
        end
        req_valid = '0; req_last = '0;
        chk("t6_end_busy", 32'(busy), 32'(0));
        chk("t6_abort",    32'(burst_abort), 32'(0));
        chk("t6_writes",   32'(wr_count - base), 32'(8));
        step(); #1;
        chk("t6_abort_after", 32'(burst_abort), 32'(0));
        chk("t6_idle_busy",   32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
